// File: rtl/instruction_store.sv
// Program memory plus valid/ready byte loader. The core is held in reset while a
// program loads, then instructions are served combinationally from pc.
//
// Handshake: a byte transfers on a rising edge when load_valid && load_ready.
// load_ready is high only in LOAD and never in the cycle load_start is
// asserted. A byte offered while load_ready is low is dropped with no effect.
module instruction_store #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  FILL       = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [7:0]            pc,
  output logic [7:0]            instruction,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   program_length,
  output logic                  overflow,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH:0]   r_program_length;
  logic                  r_overflow;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_at_end;
  logic [ADDR_WIDTH:0]   w_next_len;
  logic [CW-1:0]         w_pc_ext;
  logic [CW-1:0]         w_len_ext;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign load_ready  = (r_state == S_LOAD) && !load_start;
  assign w_accept    = load_valid && load_ready;
  assign w_at_end    = &r_wr_addr;
  assign w_next_len  = {1'b0, r_wr_addr} + (ADDR_WIDTH + 1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_wr_addr        <= '0;
      r_program_length <= '0;
      r_overflow       <= 1'b0;
    end else if (load_start) begin
      r_state          <= S_LOAD;
      r_wr_addr        <= '0;
      r_program_length <= '0;
      r_overflow       <= 1'b0;
    end else if (w_accept) begin
      r_wr_addr        <= r_wr_addr + 1'b1;
      r_program_length <= w_next_len;
      // The last memory slot ends the session; a missing load_last there means truncation.
      if (load_last || w_at_end) begin
        r_state <= S_RUN;
      end
      if (w_at_end && !load_last) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Memory is never cleared; stale bytes are hidden by the program_length bound.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_mem[r_wr_addr] <= load_data;
    end
  end

  assign w_pc_ext    = CW'(pc);
  assign w_len_ext   = CW'(r_program_length);
  assign w_rd_addr   = ADDR_WIDTH'(pc);

  assign instruction = ((r_state == S_RUN) && (w_pc_ext < w_len_ext)) ? r_mem[w_rd_addr] : FILL;
  assign cpu_reset      = (r_state != S_RUN);
  assign program_length = r_program_length;
  assign overflow       = r_overflow;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: an 8-bit-address instance (FILL 00) and a
// 2-bit-address instance (FILL FF) for the truncation cases.
module tb_instruction_store;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_RUN  = 2;

  localparam int A_RDY = 0, A_CRST = 1, A_INS = 2, A_LEN = 3, A_OVF = 4, A_ST = 5;
  localparam int B_RDY = 6, B_CRST = 7, B_INS = 8, B_LEN = 9, B_OVF = 10, B_ST = 11;

  localparam int MAX_CYCLES = 2000;

  logic clk;
  logic reset;

  logic       a_start, a_valid, a_last;
  logic [7:0] a_data, a_pc;
  logic       a_ready, a_crst, a_ovf;
  logic [7:0] a_ins;
  logic [8:0] a_len;
  logic [1:0] a_st;

  logic       b_start, b_valid, b_last;
  logic [7:0] b_data, b_pc;
  logic       b_ready, b_crst, b_ovf;
  logic [7:0] b_ins;
  logic [2:0] b_len;
  logic [1:0] b_st;

  // Each entry is {kind[7:0], expected[15:0]}.
  logic [23:0] exp_q[$];
  int n_vec;
  int n_miss;
  logic done;

  instruction_store #(.ADDR_WIDTH(8), .FILL(8'h00)) dut_a (
    .clk(clk), .reset(reset), .load_start(a_start), .load_valid(a_valid),
    .load_data(a_data), .load_last(a_last), .load_ready(a_ready), .pc(a_pc),
    .instruction(a_ins), .cpu_reset(a_crst), .program_length(a_len),
    .overflow(a_ovf), .o_dbg_state(a_st)
  );

  instruction_store #(.ADDR_WIDTH(2), .FILL(8'hFF)) dut_b (
    .clk(clk), .reset(reset), .load_start(b_start), .load_valid(b_valid),
    .load_data(b_data), .load_last(b_last), .load_ready(b_ready), .pc(b_pc),
    .instruction(b_ins), .cpu_reset(b_crst), .program_length(b_len),
    .overflow(b_ovf), .o_dbg_state(b_st)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    done = 1'b0;
    repeat (MAX_CYCLES) @(posedge clk);
    if (!done) begin
      n_miss++;
      $display("FAIL timeout: sequence did not finish within %0d cycles", MAX_CYCLES);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
    end
  end

  // Scoreboard monitor: drains expectations at the falling edge of each cycle.
  function automatic logic [15:0] actual(input int k);
    case (k)
      A_RDY:   return 16'(a_ready);
      A_CRST:  return 16'(a_crst);
      A_INS:   return 16'(a_ins);
      A_LEN:   return 16'(a_len);
      A_OVF:   return 16'(a_ovf);
      A_ST:    return 16'(a_st);
      B_RDY:   return 16'(b_ready);
      B_CRST:  return 16'(b_crst);
      B_INS:   return 16'(b_ins);
      B_LEN:   return 16'(b_len);
      B_OVF:   return 16'(b_ovf);
      B_ST:    return 16'(b_st);
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      A_RDY:   return "a_load_ready";
      A_CRST:  return "a_cpu_reset";
      A_INS:   return "a_instruction";
      A_LEN:   return "a_program_length";
      A_OVF:   return "a_overflow";
      A_ST:    return "a_state";
      B_RDY:   return "b_load_ready";
      B_CRST:  return "b_cpu_reset";
      B_INS:   return "b_instruction";
      B_LEN:   return "b_program_length";
      B_OVF:   return "b_overflow";
      B_ST:    return "b_state";
      default: return "unknown";
    endcase
  endfunction

  logic [23:0] m_ent;
  logic [15:0] m_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_ent = exp_q.pop_front();
      m_act = actual(int'(m_ent[23:16]));
      n_vec++;
      if (m_act !== m_ent[15:0]) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h at %0t", kname(int'(m_ent[23:16])),
                 m_act, m_ent[15:0], $time);
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int v);
    exp_q.push_back({k[7:0], v[15:0]});
  endtask

  task automatic a_chk(input int rdy, input int crst, input int len, input int st);
    push(A_RDY, rdy); push(A_CRST, crst); push(A_LEN, len); push(A_ST, st);
  endtask

  task automatic b_chk(input int rdy, input int crst, input int len, input int st);
    push(B_RDY, rdy); push(B_CRST, crst); push(B_LEN, len); push(B_ST, st);
  endtask

  task automatic chk_reset();
    n_vec++;
    if (a_ready !== 1'b0 || a_crst !== 1'b1 || a_len !== 9'd0 || a_ovf !== 1'b0 ||
        a_st !== 2'(ST_IDLE) || a_ins !== 8'h00 ||
        b_ready !== 1'b0 || b_crst !== 1'b1 || b_len !== 3'd0 || b_ovf !== 1'b0 ||
        b_st !== 2'(ST_IDLE) || b_ins !== 8'hFF) begin
      n_miss++;
      $display("FAIL reset state: a rdy=%b crst=%b len=%h ovf=%b st=%0d ins=%h / b rdy=%b crst=%b len=%h ovf=%b st=%0d ins=%h at %0t",
               a_ready, a_crst, a_len, a_ovf, a_st, a_ins,
               b_ready, b_crst, b_len, b_ovf, b_st, b_ins, $time);
    end
  endtask

  initial begin
    logic [7:0] t_data [5];
    logic       t_valid [5];
    logic       t_last [5];
    int         t_len [5];
    logic [7:0] t_prog [3];

    n_vec = 0; n_miss = 0;
    reset = 1'b1;
    a_start = 0; a_valid = 0; a_last = 0; a_data = 8'h00; a_pc = 8'h00;
    b_start = 0; b_valid = 0; b_last = 0; b_data = 8'h00; b_pc = 8'h00;
    t_data  = '{8'h12, 8'h99, 8'h34, 8'h99, 8'h56};
    t_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_len   = '{0, 1, 1, 2, 2};
    t_prog  = '{8'h12, 8'h34, 8'h56};
    repeat (2) cyc();
    chk_reset();

    // Reset state; a byte offered in IDLE must be dropped.
    reset = 1'b0;
    a_valid = 1'b1; a_data = 8'h5A;
    a_chk(0, 1, 0, ST_IDLE); push(A_OVF, 0); push(A_INS, 8'h00);
    b_chk(0, 1, 0, ST_IDLE); push(B_OVF, 0); push(B_INS, 8'hFF);
    cyc();
    a_valid = 1'b0; a_start = 1'b1;
    a_chk(0, 1, 0, ST_IDLE);

    // Basic three-byte load.
    cyc();
    a_start = 1'b0; a_valid = 1'b1; a_data = 8'h12; a_last = 1'b0;
    a_chk(1, 1, 0, ST_LOAD);
    cyc();
    a_data = 8'h34;
    a_chk(1, 1, 1, ST_LOAD);
    cyc();
    a_data = 8'h56; a_last = 1'b1;
    a_chk(1, 1, 2, ST_LOAD);
    cyc();
    a_valid = 1'b0; a_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_pc = 8'(i);
      a_chk(0, 0, 3, ST_RUN); push(A_INS, int'(t_prog[i]));
      cyc();
    end
    a_pc = 8'd3; push(A_INS, 8'h00);
    cyc();
    a_pc = 8'hFF; push(A_INS, 8'h00);

    // Same program with load_valid toggling; idle cycles carry junk data.
    cyc();
    a_start = 1'b1;
    a_chk(0, 0, 3, ST_RUN);
    for (int i = 0; i < 5; i++) begin
      cyc();
      a_start = 1'b0;
      a_valid = t_valid[i]; a_data = t_data[i]; a_last = t_last[i];
      a_chk(1, 1, t_len[i], ST_LOAD);
    end
    cyc();
    a_valid = 1'b0; a_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_pc = 8'(i);
      a_chk(0, 0, 3, ST_RUN); push(A_INS, int'(t_prog[i]));
      cyc();
    end
    a_pc = 8'd3; push(A_INS, 8'h00);

    // Restart from RUN; stale bytes beyond the new length stay hidden.
    cyc();
    a_pc = 8'd0; a_start = 1'b1;
    a_chk(0, 0, 3, ST_RUN); push(A_INS, 8'h12);
    cyc();
    a_start = 1'b0; a_valid = 1'b1; a_data = 8'hC1; a_last = 1'b1;
    a_chk(1, 1, 0, ST_LOAD); push(A_INS, 8'h00);
    cyc();
    a_valid = 1'b0; a_last = 1'b0; a_pc = 8'd1;
    a_chk(0, 0, 1, ST_RUN); push(A_INS, 8'h00);
    cyc();
    a_pc = 8'd0; push(A_INS, 8'hC1);

    // load_start with a valid byte mid-LOAD: byte dropped, address rewinds.
    cyc();
    a_start = 1'b1;
    cyc();
    a_start = 1'b0; a_valid = 1'b1; a_data = 8'hAA;
    a_chk(1, 1, 0, ST_LOAD);
    cyc();
    a_data = 8'hBB;
    a_chk(1, 1, 1, ST_LOAD);
    cyc();
    a_start = 1'b1; a_data = 8'hEE;
    a_chk(0, 1, 2, ST_LOAD);
    cyc();
    a_start = 1'b0; a_data = 8'h77; a_last = 1'b1;
    a_chk(1, 1, 0, ST_LOAD);
    cyc();
    a_valid = 1'b0; a_last = 1'b0; a_pc = 8'd0;
    a_chk(0, 0, 1, ST_RUN); push(A_INS, 8'h77);

    // Reset mid-LOAD, with a byte offered in the reset cycle.
    cyc();
    a_start = 1'b1;
    cyc();
    a_start = 1'b0; a_valid = 1'b1; a_data = 8'hD1;
    cyc();
    a_data = 8'hD2;
    a_chk(1, 1, 1, ST_LOAD);
    cyc();
    reset = 1'b1; a_data = 8'hD3;
    a_chk(1, 1, 2, ST_LOAD);
    cyc();
    reset = 1'b0; a_valid = 1'b0; a_pc = 8'd0;
    a_chk(0, 1, 0, ST_IDLE); push(A_OVF, 0); push(A_INS, 8'h00);

    // Four-entry memory: truncation without load_last.
    cyc();
    b_start = 1'b1;
    b_chk(0, 1, 0, ST_IDLE);
    for (int i = 0; i < 4; i++) begin
      cyc();
      b_start = 1'b0; b_valid = 1'b1; b_data = 8'hA0 + 8'(i); b_last = 1'b0;
      b_chk(1, 1, i, ST_LOAD); push(B_OVF, 0);
    end
    cyc();
    b_data = 8'hA4; b_pc = 8'd3;
    b_chk(0, 0, 4, ST_RUN); push(B_OVF, 1); push(B_INS, 8'hA3);
    cyc();
    b_valid = 1'b0; b_pc = 8'd0;
    b_chk(0, 0, 4, ST_RUN); push(B_OVF, 1); push(B_INS, 8'hA0);
    cyc();
    b_pc = 8'd4; push(B_INS, 8'hFF);

    // Full memory with load_last on the final slot: no overflow.
    cyc();
    b_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      b_start = 1'b0; b_valid = 1'b1; b_data = 8'hB0 + 8'(i); b_last = (i == 3);
      b_chk(1, 1, i, ST_LOAD); push(B_OVF, 0);
    end
    cyc();
    b_valid = 1'b0; b_last = 1'b0; b_pc = 8'd3;
    b_chk(0, 0, 4, ST_RUN); push(B_OVF, 0); push(B_INS, 8'hB3);

    cyc();
    cyc();
    done = 1'b1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d expectations never checked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule

// File: doc/instruction_store.md
# instruction_store

Program memory and loader that feeds the microprocessor core its `instruction` byte, indexed by the core's `pc`. It accepts a program as a valid/ready byte stream and holds the core in reset while loading. Once the last byte is accepted it releases the core and serves instructions combinationally from `pc`. It sits between the board-level program source (switch/serial front end) and the core's `instruction`/`pc` ports.

## Interface

- `ADDR_WIDTH`, default 8: memory address width; `DEPTH` = 2**`ADDR_WIDTH` bytes.
- `FILL`, default 8'h00: instruction returned for any unloaded address or when not in RUN.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_start`  in  1  one-cycle request to begin a new programming session.
- `load_valid`  in  1  `load_data` holds a program byte.
- `load_data`  in  8  program byte.
- `load_last`  in  1  qualifies the current byte as the final one; sampled only on accept.
- `load_ready`  out  1  block can accept a byte this cycle.
- `pc`  in  8  core program counter.
- `instruction`  out  8  byte at `pc`, combinational.
- `cpu_reset`  out  1  high to hold the core in reset.
- `program_length`  out  `ADDR_WIDTH`+1  number of bytes in the current program.
- `overflow`  out  1  sticky flag: the program was truncated at `DEPTH` bytes.

## Operation

- FSM states: IDLE, LOAD, RUN.
- Reset: state IDLE, write address 0, `program_length` 0, `overflow` 0.
  - Memory contents are not cleared.
  - Outputs after reset: `load_ready` 0, `cpu_reset` 1, `instruction` `FILL`.
- `load_start` in any state (IDLE, LOAD, RUN) moves to LOAD. It also clears the write address, `program_length` and `overflow`.
- `load_ready` = (state == LOAD) && !`load_start`.
- Accept = `load_valid` && `load_ready`. On accept:
  - write `mem[wr_addr]` = `load_data`;
  - increment `wr_addr`;
  - `program_length` <= `wr_addr` + 1.
- Leaving LOAD:
  - An accept with `load_last` = 1 moves to RUN.
  - An accept at `wr_addr` == `DEPTH`-1 with `load_last` = 0 moves to RUN and sets `overflow`.
  - An accept at `wr_addr` == `DEPTH`-1 with `load_last` = 1 moves to RUN, `overflow` stays 0.
- `load_valid` while not ready: the byte is ignored, with no side effects. This covers IDLE, RUN, and the cycle of `load_start`.
- `cpu_reset` = (state != RUN), decoded directly from the state register.
- `instruction` = `mem[pc]` when state == RUN and `pc` < `program_length`; otherwise `FILL`.
  - The read is asynchronous (combinational from `pc`).
  - `pc` bits above `ADDR_WIDTH` count in the comparison.
- An empty session is impossible: LOAD exits only on an accepted byte, so `program_length` >= 1 in RUN.
- `reset` overrides `load_start` and accepts in the same cycle. Reset mid-LOAD returns to IDLE and discards the partial program length.

## Timing

- Byte throughput: 1 byte/cycle in LOAD.
- `load_start` at edge N:
  - `load_ready` 1 from cycle N+1;
  - `cpu_reset` 1 from cycle N+1;
  - `program_length` 0 from cycle N+1.
- Final byte accepted at edge M:
  - state RUN, `cpu_reset` 0 and `load_ready` 0 from cycle M+1;
  - that byte is readable via `pc` in cycle M+1.
- `instruction` follows `pc` in the same cycle (zero latency). The core changes `pc` mid-cycle and latches results on the next rising edge.
- `program_length` and `overflow` update at the edge of the accepting byte.

## Test plan

- Reset, then `load_start`, then bytes 8'h12, 8'h34, 8'h56 with `load_last` on 8'h56:
  - `load_ready` 1 for 3 cycles;
  - `cpu_reset` falls the cycle after 8'h56;
  - `program_length` = 3;
  - `pc` = 0/1/2 gives 8'h12/8'h34/8'h56;
  - `pc` = 3 gives `FILL`.
- Same load with `load_valid` toggling 1,0,1,0,1:
  - exactly 3 bytes stored, in order;
  - `program_length` goes 1, 2, 3;
  - no writes on the idle cycles.
- `ADDR_WIDTH` = 2, five bytes 8'hA0–8'hA4, no `load_last`:
  - after 8'hA3, state is RUN and `overflow` = 1;
  - `load_ready` = 0, so 8'hA4 is ignored;
  - `program_length` = 4;
  - `pc` = 3 gives 8'hA3.
- In RUN with a 3-byte program, pulse `load_start`:
  - `cpu_reset` = 1 and `instruction` = `FILL` the next cycle;
  - then load 1 byte 8'hC1 with `load_last`: `program_length` = 1, `pc` = 1 gives `FILL` (stale 8'h34 not visible).
- `load_start` and `load_valid` (data 8'hEE) together while in LOAD after 2 bytes:
  - 8'hEE not written;
  - write address 0, `program_length` 0.
- Assert `reset` mid-LOAD after 2 bytes:
  - next cycle state IDLE, `cpu_reset` 1, `load_ready` 0, `program_length` 0;
  - `instruction` = `FILL` for `pc` = 0.
